// File: rtl/vga_timing_gen.sv
// Programmable VGA sync/timing generator with pixel-fetch strobe, matched-delay
// sync/DE pipeline and a built-in test-pattern source.
module vga_timing_gen #(
  parameter int unsigned H_VIZ    = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 144,
  parameter int unsigned V_VIZ    = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned H_POL    = 0,
  parameter int unsigned V_POL    = 0,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [1:0]    pattern_sel,
  input  logic [11:0]   pix_in,
  output logic          px_req,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [3:0]    r,
  output logic [3:0]    g,
  output logic [3:0]    b
);

  localparam int unsigned H_TOTAL  = H_VIZ + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIZ + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VIZ + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VIZ + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned BAR_W    = H_VIZ / 8;
  localparam logic        H_ACT    = 1'(H_POL);
  localparam logic        V_ACT    = 1'(V_POL);

  // One delay-line entry: everything that must stay aligned with de.
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        ext;
    logic [11:0] rgb;
  } stage_t;

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    pat_q, pat_d;
  logic          run_c;
  logic [1:0]    pat_eff_c;
  logic [2:0]    bar_c;
  logic          chk_c;
  stage_t        stage0_c;
  stage_t        dly_q [PIPE_DLY];
  stage_t        tail_c;

  assign run_c = enable & ~rst;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (enable) begin
      if (h_cnt_q == CW'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == CW'(V_TOTAL - 1)) ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end
  end

  assign px_x        = h_cnt_q;
  assign px_y        = v_cnt_q;
  assign line_start  = run_c && (h_cnt_q == '0);
  assign frame_start = line_start && (v_cnt_q == '0);
  assign px_req      = run_c && (h_cnt_q < CW'(H_VIZ)) && (v_cnt_q < CW'(V_VIZ));

  // The frame's first pixel already uses the newly selected pattern.
  assign pat_eff_c = frame_start ? pattern_sel : pat_q;
  assign pat_d     = pat_eff_c;
  assign bar_c     = 3'(h_cnt_q / CW'(BAR_W));
  assign chk_c     = 1'((h_cnt_q >> 5) ^ (v_cnt_q >> 5));

  always_comb begin
    stage0_c     = '0;
    stage0_c.de  = px_req;
    stage0_c.hs  = run_c && (h_cnt_q >= CW'(HS_START)) && (h_cnt_q < CW'(HS_END));
    stage0_c.vs  = run_c && (v_cnt_q >= CW'(VS_START)) && (v_cnt_q < CW'(VS_END));
    unique case (pat_eff_c)
      2'd0: stage0_c.ext = 1'b1;
      2'd1: stage0_c.rgb = {{4{~bar_c[1]}}, {4{~bar_c[2]}}, {4{~bar_c[0]}}};
      2'd2: stage0_c.rgb = chk_c ? 12'hFFF : 12'h000;
      default: stage0_c.rgb = 12'hFFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      pat_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      pat_q   <= pat_d;
    end
  end

  // Delay line keeps shifting while disabled so the outputs drain to blank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= stage0_c;
      for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign tail_c    = dly_q[PIPE_DLY-1];
  assign de        = tail_c.de;
  assign h_sync    = tail_c.hs ? H_ACT : ~H_ACT;
  assign v_sync    = tail_c.vs ? V_ACT : ~V_ACT;
  // External pixels arrive already delayed by the fetch pipeline.
  assign {r, g, b} = !tail_c.de ? 12'h000 : (tail_c.ext ? pix_in : tail_c.rgb);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 1024x768 timing plus a tiny
// positive-polarity configuration for frame-level and pattern-latch behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Default-timing instance
  logic        rst, en;
  logic [1:0]  pat;
  logic [11:0] pix;
  logic        px_req, ls, fs, hs, vs, de;
  logic [10:0] px_x, px_y;
  logic [3:0]  r, g, b;
  logic [11:0] rgb;
  assign rgb = {r, g, b};

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .enable(en), .pattern_sel(pat), .pix_in(pix),
    .px_req(px_req), .px_x(px_x), .px_y(px_y), .line_start(ls),
    .frame_start(fs), .h_sync(hs), .v_sync(vs), .de(de), .r(r), .g(g), .b(b)
  );

  // Small positive-polarity instance, H 8/2/2/2, V 4/1/1/1, 3-clock pipe
  logic        rst_s, en_s;
  logic [1:0]  pat_s;
  logic [11:0] pix_s;
  logic        px_req_s, ls_s, fs_s, hs_s, vs_s, de_s;
  logic [3:0]  px_x_s, px_y_s;
  logic [3:0]  r_s, g_s, b_s;
  logic [11:0] rgb_s;
  assign rgb_s = {r_s, g_s, b_s};

  vga_timing_gen #(
    .H_VIZ(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIZ(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .PIPE_DLY(3), .CW(4)
  ) u_sm (
    .clk(clk), .rst(rst_s), .enable(en_s), .pattern_sel(pat_s), .pix_in(pix_s),
    .px_req(px_req_s), .px_x(px_x_s), .px_y(px_y_s), .line_start(ls_s),
    .frame_start(fs_s), .h_sync(hs_s), .v_sync(vs_s), .de(de_s),
    .r(r_s), .g(g_s), .b(b_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pix_of(input int x);
    return 12'((x * 37 + 5) ^ 12'h5A5);
  endfunction

  initial begin
    int hs_first, hs_cnt, de_first, de_cnt, ls_second, bad, fs_cnt;
    logic [11:0] pv;
    logic de_exp;

    rst = 1'b1; en = 1'b1; pat = 2'd1; pix = '0;
    rst_s = 1'b1; en_s = 1'b1; pat_s = 2'd3; pix_s = '0;
    repeat (3) step();

    check("rst_de", de, 0);
    check("rst_rgb", rgb, 0);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_px_req", px_req, 0);
    check("rst_ls", ls, 0);
    check("rst_fs", fs, 0);
    check("rst_hs_small", hs_s, 0);
    check("rst_vs_small", vs_s, 0);

    // Line 0 with colour bars
    rst = 1'b0; #1;
    hs_first = -1; hs_cnt = 0; de_first = -1; de_cnt = 0; ls_second = -1;
    for (int c = 0; c < 1332; c++) begin
      if (c < 1328) begin
        if (!hs) begin
          if (hs_first < 0) hs_first = c;
          hs_cnt++;
        end
        if (de) begin
          if (de_first < 0) de_first = c;
          de_cnt++;
        end
      end
      if (ls && c > 0 && ls_second < 0) ls_second = c;
      case (c)
        0: begin
          check("first_fs", fs, 1);
          check("first_x", px_x, 0);
          check("first_y", px_y, 0);
          check("first_req", px_req, 1);
        end
        2:    check("bar_x0", rgb, 12'hFFF);
        129:  check("bar_x127", rgb, 12'hFFF);
        130:  check("bar_x128", rgb, 12'hFF0);
        258:  check("bar_x256", rgb, 12'h0FF);
        386:  check("bar_x384", rgb, 12'h0F0);
        642:  check("bar_x640", rgb, 12'hF00);
        898:  begin check("bar_x896", rgb, 12'h000); check("bar_x896_de", de, 1); end
        1025: check("de_last", de, 1);
        1026: check("de_off", de, 0);
        1100: check("blank_rgb", rgb, 0);
        1328: begin check("wrap_x", px_x, 0); check("wrap_y", px_y, 1); end
        default: ;
      endcase
      step();
    end
    check("hs_first", hs_first, 1050);
    check("hs_width", hs_cnt, 136);
    check("de_first", de_first, 2);
    check("de_count", de_cnt, 1024);
    check("line_period", ls_second, 1328);

    // External pixels; mid-frame select change must not take effect
    rst = 1'b1; pat = 2'd0; step(); step();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 1100; c++) begin
      pv = (c >= 2) ? pix_of(c - 2) : 12'h000;
      pix = pv;
      if (c == 500) pat = 2'd3;
      #1;
      de_exp = (c >= 2) && (c < 1026);
      if (de !== de_exp || rgb !== (de_exp ? pv : 12'h000)) bad++;
      if (c == 2) check("ext_x0", rgb, pix_of(0));
      if (c == 700) check("ext_x698", rgb, pix_of(698));
      step();
    end
    check("ext_mismatches", bad, 0);
    pix = '0;

    // Checkerboard on line 0
    rst = 1'b1; pat = 2'd2; step(); step();
    rst = 1'b0; #1;
    for (int c = 0; c < 70; c++) begin
      if (c == 33) check("chk_x31", rgb, 12'h000);
      if (c == 34) check("chk_x32", rgb, 12'hFFF);
      if (c == 66) check("chk_x64", rgb, 12'h000);
      step();
    end

    // Enable drop mid-line, then reset inside the sync pulse
    rst = 1'b1; pat = 2'd3; step(); step();
    rst = 1'b0;
    repeat (100) step();
    en = 1'b0; #1;
    check("dis_req", px_req, 0);
    check("dis_x", px_x, 100);
    check("dis_ls", ls, 0);
    repeat (50) step();
    check("dis_hold_x", px_x, 100);
    check("dis_de", de, 0);
    check("dis_rgb", rgb, 0);
    check("dis_hs", hs, 1);
    en = 1'b1; #1;
    check("ren_req", px_req, 1);
    step();
    check("ren_x", px_x, 101);
    step();
    check("ren_de", de, 1);
    check("ren_rgb", rgb, 12'hFFF);
    repeat (998) step();
    check("pre_rst_x", px_x, 1100);
    check("pre_rst_hs", hs, 0);
    rst = 1'b1; step();
    check("mid_rst_x", px_x, 0);
    check("mid_rst_hs", hs, 1);
    check("mid_rst_de", de, 0);
    check("mid_rst_fs", fs, 0);
    check("mid_rst_req", px_req, 0);
    rst = 1'b0; #1;
    check("post_rst_fs", fs, 1);
    check("post_rst_y", px_y, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_rst_hs", hs, 1);
    end

    // Small instance: polarity, vertical timing, wrap and pattern latch
    rst_s = 1'b0; #1;
    fs_cnt = 0; de_cnt = 0;
    for (int c = 0; c < 112; c++) begin
      if (c == 40) pat_s = 2'd1;
      if (c < 98) begin
        if (fs_s) fs_cnt++;
        if (de_s) de_cnt++;
      end
      case (c)
        3:   begin check("s_de_x0", de_s, 1); check("s_rgb_x0", rgb_s, 12'hFFF); end
        12:  check("s_hs_12", hs_s, 0);
        13:  check("s_hs_13", hs_s, 1);
        14:  check("s_hs_14", hs_s, 1);
        15:  check("s_hs_15", hs_s, 0);
        46:  check("s_old_pat", rgb_s, 12'hFFF);
        72:  check("s_vs_72", vs_s, 0);
        73:  check("s_vs_73", vs_s, 1);
        86:  check("s_vs_86", vs_s, 1);
        87:  check("s_vs_87", vs_s, 0);
        97:  begin check("s_last_x", px_x_s, 13); check("s_last_y", px_y_s, 6); end
        98:  begin
          check("s_wrap_x", px_x_s, 0);
          check("s_wrap_y", px_y_s, 0);
          check("s_wrap_fs", fs_s, 1);
        end
        102: check("s_new_pat_x1", rgb_s, 12'hFF0);
        108: begin check("s_new_pat_x7", rgb_s, 12'h000); check("s_de_x7", de_s, 1); end
        109: check("s_de_x8", de_s, 0);
        default: ;
      endcase
      step();
    end
    check("s_fs_count", fs_cnt, 1);
    check("s_de_count", de_cnt, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
